// File: rtl/input_buffer_if.sv
// rtl/input_buffer_if.sv - burst request/handshake bundle for the activation input buffer
interface input_buffer_if #(
  parameter int address_width = 12
);
  logic                     enable;
  logic                     rwEn;
  logic [address_width-1:0] address;
  logic                     ready;

  modport master (
    output enable,
    output rwEn,
    output address,
    input  ready
  );

  modport slave (
    input  enable,
    input  rwEn,
    input  address,
    output ready
  );
endinterface

// File: rtl/input_buffer.sv
// rtl/input_buffer.sv - activation input buffer moving synopseFold-word bursts over a shared bus
// Optional feature: INPUT_BUFFER_WRAP_EN (burst address wraps instead of stopping at the top word).
module input_buffer #(
  parameter int address_width       = 12,
  parameter int synopseFold         = 18,
  parameter int simd_width          = 32,
  parameter int binary_input_levels = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input_buffer_if.slave                              bus,
  inout  wire [simd_width*binary_input_levels-1:0]   data
);
  localparam int W     = simd_width * binary_input_levels;
  localparam int DEPTH = 2 ** address_width;
  localparam int CNT_W = $clog2(synopseFold + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [address_width-1:0] ptr;
  logic [CNT_W-1:0]   cnt;
  logic               mode;
  logic               oe;
  logic               ready_q;
  logic [W-1:0]       dout;
  logic [W-1:0]       mem [DEPTH];

  logic access;
  logic last;

  assign access = (state == BURST) && bus.enable;

`ifdef INPUT_BUFFER_WRAP_EN
  assign last = (cnt == CNT_W'(synopseFold - 1));
`else
  // Without wrap the burst is cut short at the top word so ptr never rolls over.
  assign last = (cnt == CNT_W'(synopseFold - 1)) || (&ptr);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
      oe      <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b0;
          oe      <= 1'b0;
          if (bus.enable) begin
            ptr   <= bus.address;
            cnt   <= '0;
            mode  <= bus.rwEn;
            state <= BURST;
          end
        end
        BURST: begin
          if (!bus.enable) begin
            ready_q <= 1'b0;
            oe      <= 1'b0;
            state   <= IDLE;
          end else begin
            ready_q <= 1'b1;
            oe      <= mode;
            ptr     <= ptr + 1'b1;
            cnt     <= cnt + 1'b1;
            if (last) state <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          oe      <= 1'b0;
          if (!bus.enable) state <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          oe      <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (access) begin
      if (mode) dout <= mem[ptr];
      else      mem[ptr] <= data;
    end
  end

  assign bus.ready = ready_q;
  assign data      = oe ? dout : {W{1'bz}};
endmodule

// File: tb/tb_input_buffer.sv
// tb/tb_input_buffer.sv - self-checking bench for input_buffer (table vectors plus random bursts)
module tb_input_buffer;
  localparam int AW    = 12;
  localparam int FOLD  = 18;
  localparam int W     = 64;
  localparam int DEPTH = 1 << AW;
`ifdef INPUT_BUFFER_WRAP_EN
  localparam int TOPK = 18;
`else
  localparam int TOPK = 6;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tb_oe = 1'b0;
  logic [W-1:0]  tb_dout = '0;
  wire  [W-1:0]  data;

  input_buffer_if #(.address_width(AW)) bus ();

  assign data = tb_oe ? tb_dout : {W{1'bz}};

  input_buffer #(
    .address_width(AW),
    .synopseFold(FOLD),
    .simd_width(32),
    .binary_input_levels(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .data(data)
  );

  always #50 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] model [int];

  typedef struct {
    logic         rw;
    int           addr;
    int           hold;
    int           exp_k;
    logic [W-1:0] seed;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic released();
    return $isunknown(data) || (data == '0);
  endfunction

  function automatic int expected_words(input int addr, input int hold);
    int k;
    k = (hold - 1 < FOLD) ? hold - 1 : FOLD;
    if (k < 0) k = 0;
`ifndef INPUT_BUFFER_WRAP_EN
    if (k > DEPTH - addr) k = DEPTH - addr;
`endif
    return k;
  endfunction

  function automatic logic [W-1:0] model_word(input int a);
    return model.exists(a) ? model[a] : {W{1'bx}};
  endfunction

  // Enable is high for `hold` edges (E0..E_hold-1); words move at E1..E_k.
  task automatic run_burst(input logic rw, input int addr, input int hold, input int k,
                           input logic [W-1:0] seed);
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.rwEn    = rw;
    bus.address = AW'(addr);
    tb_oe       = 1'b0;
    for (int c = 1; c <= hold + 2; c++) begin
      @(negedge clk);
      if (c - 1 >= 1 && c - 1 <= k) begin
        check("ready_high", {63'd0, bus.ready}, 64'd1);
        if (rw) check("read_word", data, model_word((addr + c - 2) % DEPTH));
      end else begin
        check("ready_low", {63'd0, bus.ready}, 64'd0);
        if (rw) check("bus_release", {63'd0, released()}, 64'd1);
      end
      bus.enable  = (c < hold);
      bus.rwEn    = 1'($urandom);
      bus.address = AW'($urandom);
      tb_oe       = !rw && (c <= hold - 1);
      tb_dout     = seed + W'(c - 1);
      if (!rw && c <= k) model[(addr + c - 1) % DEPTH] = seed + W'(c - 1);
    end
    tb_oe = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    bus.enable  = 1'b0;
    bus.rwEn    = 1'b0;
    bus.address = '0;

    vecs.push_back('{1'b0, 2,    20, 18,   64'hC0DE_0000_0000_0000});
    vecs.push_back('{1'b1, 2,    20, 18,   64'h0});
    vecs.push_back('{1'b1, 2,     4,  3,   64'h0});
    vecs.push_back('{1'b1, 2,     1,  0,   64'h0});
    vecs.push_back('{1'b1, 2,     2,  1,   64'h0});
    vecs.push_back('{1'b1, 2,    30, 18,   64'h0});
    vecs.push_back('{1'b0, 100,  19, 18,   64'h5A5A_1234_0000_0100});
    vecs.push_back('{1'b1, 100,  19, 18,   64'h0});
    vecs.push_back('{1'b0, 4090, 20, TOPK, 64'h7777_0000_0000_4090});
    vecs.push_back('{1'b1, 4090, 20, TOPK, 64'h0});
    vecs.push_back('{1'b0, 0,    25, 18,   64'h1111_0000_0000_0000});
    vecs.push_back('{1'b0, 18,   25, 18,   64'h2222_0000_0000_0000});
    vecs.push_back('{1'b0, 36,   25, 18,   64'h3333_0000_0000_0000});
    vecs.push_back('{1'b1, 0,    25, 18,   64'h0});

    repeat (2) @(negedge clk);
    check("reset_ready", {63'd0, bus.ready}, 64'd0);
    check("reset_release", {63'd0, released()}, 64'd1);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", {63'd0, bus.ready}, 64'd0);
    end

    foreach (vecs[i])
      run_burst(vecs[i].rw, vecs[i].addr, vecs[i].hold, vecs[i].exp_k, vecs[i].seed);

    // Reset while a read burst is streaming word 5.
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.rwEn    = 1'b1;
    bus.address = AW'(2);
    repeat (6) @(negedge clk);
    check("mid_ready", {63'd0, bus.ready}, 64'd1);
    check("mid_word5", data, model_word(6));
    #10 rst = 1'b0;
    #1;
    check("rst_ready", {63'd0, bus.ready}, 64'd0);
    check("rst_release", {63'd0, released()}, 64'd1);
    @(negedge clk);
    bus.enable = 1'b0;
    check("rst_hold_ready", {63'd0, bus.ready}, 64'd0);
    rst = 1'b1;
    run_burst(1'b1, 2, 20, 18, '0);

    for (int n = 0; n < 25; n++) begin
      logic         rw;
      int           a;
      int           h;
      logic [W-1:0] s;
      rw = 1'($urandom);
      a  = int'($urandom_range(0, 35));
      h  = int'($urandom_range(1, 25));
      s  = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      run_burst(rw, a, h, expected_words(a, h), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/input_buffer.md
# input_buffer

Activation input buffer for the binarized-network datapath. It holds multi-level binarized input vectors, one SIMD word per address, and moves them in bursts of `synopseFold` consecutive words. Each burst starts at a latched base address and is either a read (words streamed onto a shared bus) or a write (words captured from it). It sits between the input DMA/streamer and the matrix-vector compute unit, which consumes one word per fold step.

## Interface
Parameters:
- `address_width`, default 12: address bits; depth = 2^address_width words.
- `synopseFold`, default 18: words per burst.
- `simd_width`, default 32: SIMD lanes per word.
- `binary_input_levels`, default 2: binarization levels per lane. Word width W = simd_width*binary_input_levels (default 64).

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `enable`  in  1: burst request/hold.
- `rwEn`  in  1: 1 = read burst, 0 = write burst; sampled at burst start.
- `address`  in  address_width: burst base address; sampled at burst start.
- `data`  inout  W: shared word bus.
  - Driven by the block only while a read word is valid.
  - High-Z otherwise.
  - Sampled as write data during write bursts.
- `ready`  out  1: word valid (read) / word accepted (write) this cycle.

## Operation
- Storage: 2^address_width x W array. Contents are not reset; they are undefined until written.
- States:
  - IDLE: ready=0, bus released. If `enable`=1 at an edge, latch ptr<=address, cnt<=0, mode<=rwEn, go to BURST.
  - BURST, with `enable`=0 at an edge: abort. ready<=0, go to IDLE. No access that cycle.
  - BURST, with `enable`=1, read mode: dout<=mem[ptr], oe<=1, ready<=1.
  - BURST, with `enable`=1, write mode: mem[ptr]<=data, ready<=1, oe<=0.
  - BURST access bookkeeping: ptr<=ptr+1 and cnt<=cnt+1. If cnt==synopseFold-1, go to DONE.
  - DONE: ready<=0, oe<=0. Stay until `enable`=0, then go to IDLE. A held `enable` does not retrigger.
- `rwEn` and `address` changes during BURST/DONE are ignored.
- `data` = oe ? dout : 'z.
- Counter width: ceil(log2(synopseFold+1)) bits.

## Timing
- Reset (async assert): state=IDLE, ready=0, oe=0 (data high-Z), ptr=0, cnt=0. Deassertion takes effect at the next edge.
- Start: `enable` sampled high at edge E0 enters BURST. The first access happens at E1.
  - Read: data=mem[A] and ready=1 are visible after E1, i.e. 2 edges after the request.
  - Write: the word present on `data` at E1 is written to A.
- Throughput: one word per cycle. A full burst gives ready high for exactly synopseFold consecutive cycles (E1..E_synopseFold).
- After the last access, ready falls at the next edge (DONE).
- An abort drops ready and releases the bus at the abort edge. Partial write data remains stored.
- Reset asserted mid-burst: immediate return to IDLE, ready=0, bus released. Memory is unaffected.
- Simultaneous end of burst and `enable` falling: the last access completes and the state goes to DONE. It then returns to IDLE on the next edge with `enable`=0.

## Configuration
- `INPUT_BUFFER_WRAP_EN` defined: ptr increments modulo 2^address_width. A burst starting near the top wraps to address 0.
- Undefined: a burst stops after the access at address 2^address_width-1 and goes to DONE, even if cnt<synopseFold-1. No wrap ever occurs.

## Test plan
- Reset: rst=0 for 2 cycles -> ready=0, data=Z. Release, enable=0 -> stays idle, ready=0.
- Write then read:
  - Write burst at address 2 with words 0x...0000+i (i=0..17) -> ready high 18 cycles.
  - Read burst at address 2 -> ready high 18 cycles, data=written words in order, first valid 2 edges after request.
- Abort: read at address 2, enable high 3.5 cycles (toggle at 100 ns period) -> 2-3 words (mem[2], mem[3], ...) with ready=1, then ready=0 and data=Z the edge after enable falls.
- Held enable: enable held 30 cycles -> exactly 18 ready cycles, then no restart until enable drops and re-rises.
- Top-of-memory burst at address 4090:
  - With `INPUT_BUFFER_WRAP_EN`: 18 words from addresses 4090..4095, 0..11.
  - Without: 6 words, then DONE.
- Reset mid-burst at word 5 -> ready=0 and data=Z immediately. A subsequent read returns the earlier-written contents.
